// File: rtl/calc_pkg.sv
// Shared types and constants for the expression buffer editor.
package calc_pkg;

    localparam int unsigned BUTTONS = 27;
    localparam int unsigned PAGE    = 16;
    localparam int unsigned DEPTH   = 2 * PAGE;
    localparam int unsigned WIDTH   = 8;

    // Control keys occupy the top four keypad lines.
    localparam int unsigned KEY_LEFT  = BUTTONS - 4;
    localparam int unsigned KEY_RIGHT = BUTTONS - 3;
    localparam int unsigned KEY_DEL   = BUTTONS - 2;
    localparam int unsigned KEY_CLR   = BUTTONS - 1;

    localparam logic [WIDTH-1:0] BLANK_TOKEN = '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT_R = 2'd1,
        S_SHIFT_L = 2'd2,
        S_COMMIT  = 2'd3
    } state_t;

endpackage

// File: rtl/key_edge_encoder.sv
// Rising-edge detect on the keypad lines with lowest-index-wins priority encode.
module key_edge_encoder #(
    parameter int unsigned buttons = 27
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [buttons-1:0]         btn,
    output logic                       key_valid,
    output logic [$clog2(buttons)-1:0] key_idx
);

    localparam int unsigned KW = $clog2(buttons);

    logic [buttons-1:0] btn_q;
    logic [buttons-1:0] edges;

    // Previous button levels; cleared on reset so a held key reads as a fresh press.
    always_ff @(posedge clock) begin
        if (!reset) btn_q <= '0;
        else        btn_q <= btn;
    end

    assign edges = btn & ~btn_q;

    // Scan from the top so the lowest asserted edge is the one left standing.
    always_comb begin
        key_valid = 1'b0;
        key_idx   = '0;
        for (int i = buttons - 1; i >= 0; i--) begin
            if (edges[i]) begin
                key_valid = 1'b1;
                key_idx   = KW'(i);
            end
        end
    end

endmodule

// File: rtl/expr_buffer_editor.sv
// Token buffer editor: turns keypad presses into insert/delete/cursor/clear edits.
module expr_buffer_editor
    import calc_pkg::*;
#(
    parameter int unsigned buttons = BUTTONS,
    parameter int unsigned page    = PAGE,
    parameter int unsigned depth   = DEPTH,
    parameter int unsigned width   = WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [buttons-1:0]           btn,
    output logic [width-1:0]             mem [depth-1:0],
    output logic [$clog2(depth+1)-1:0]   sizeOut,
    output logic [$clog2(depth+1)-1:0]   ptrOut,
    output logic                         jump,
    output logic                         busy,
    output logic                         full
);

    localparam int unsigned IW = $clog2(depth + 1);
    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned KW = $clog2(buttons);

    // Control key positions kept relative to the actual keypad size.
    localparam int unsigned K_LEFT  = buttons - (BUTTONS - KEY_LEFT);
    localparam int unsigned K_RIGHT = buttons - (BUTTONS - KEY_RIGHT);
    localparam int unsigned K_DEL   = buttons - (BUTTONS - KEY_DEL);
    localparam int unsigned K_CLR   = buttons - (BUTTONS - KEY_CLR);

    state_t             state, state_n;
    logic [IW-1:0]      idx, idx_n;
    logic [width-1:0]   code, code_n;
    logic [width-1:0]   mem_n [depth-1:0];
    logic [IW-1:0]      size_n, ptr_n;
    logic               jump_n, busy_n;
    logic               key_valid;
    logic [KW-1:0]      key_idx;
    logic               key_go;
    logic [AW-1:0]      at, at_m1, at_p1, last;

    key_edge_encoder #(.buttons(buttons)) u_keys (
        .clock     (clock),
        .reset     (reset),
        .btn       (btn),
        .key_valid (key_valid),
        .key_idx   (key_idx)
    );

    assign key_go = key_valid & ~busy;
    assign full   = (sizeOut == IW'(depth));
    assign at     = AW'(idx);
    assign at_m1  = AW'(idx - IW'(1));
    assign at_p1  = AW'(idx + IW'(1));
    assign last   = AW'(sizeOut - IW'(1));

    // State and buffer registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            code    <= '0;
            mem     <= '{default: '0};
            sizeOut <= '0;
            ptrOut  <= '0;
            jump    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            code    <= code_n;
            mem     <= mem_n;
            sizeOut <= size_n;
            ptrOut  <= ptr_n;
            jump    <= jump_n;
            busy    <= busy_n;
        end
    end

    // Edit sequencing; size and cursor only move together with the final memory write.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        code_n  = code;
        mem_n   = mem;
        size_n  = sizeOut;
        ptr_n   = ptrOut;

        unique case (state)
            S_IDLE: begin
                if (key_go) begin
                    if (key_idx < KW'(K_LEFT)) begin
                        if (!full) begin
                            code_n  = width'(key_idx) + width'(1);
                            idx_n   = sizeOut;
                            state_n = (sizeOut == ptrOut) ? S_COMMIT : S_SHIFT_R;
                        end
                    end else if (key_idx == KW'(K_LEFT)) begin
                        if (ptrOut != '0) ptr_n = ptrOut - IW'(1);
                    end else if (key_idx == KW'(K_RIGHT)) begin
                        if (ptrOut < sizeOut) ptr_n = ptrOut + IW'(1);
                    end else if (key_idx == KW'(K_DEL)) begin
                        if (ptrOut != '0) begin
                            idx_n   = ptrOut - IW'(1);
                            state_n = S_SHIFT_L;
                        end
                    end else if (key_idx == KW'(K_CLR)) begin
                        mem_n  = '{default: width'(BLANK_TOKEN)};
                        size_n = '0;
                        ptr_n  = '0;
                    end
                end
            end
            S_SHIFT_R: begin
                mem_n[at] = mem[at_m1];
                idx_n     = idx - IW'(1);
                if ((idx - IW'(1)) == ptrOut) state_n = S_COMMIT;
            end
            S_COMMIT: begin
                mem_n[AW'(ptrOut)] = code;
                size_n  = sizeOut + IW'(1);
                ptr_n   = ptrOut + IW'(1);
                state_n = S_IDLE;
            end
            S_SHIFT_L: begin
                if (idx < (sizeOut - IW'(1))) begin
                    mem_n[at] = mem[at_p1];
                    idx_n     = idx + IW'(1);
                end else begin
                    mem_n[last] = width'(BLANK_TOKEN);
                    size_n  = sizeOut - IW'(1);
                    ptr_n   = ptrOut - IW'(1);
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        jump_n = ((ptr_n >= IW'(page)) != (ptrOut >= IW'(page)));
        busy_n = (state_n != S_IDLE);
    end

endmodule
